// File: rtl/psk_frame_pkg.sv
// Shared definitions for the PSK framer / deframer pair: receiver state
// encoding, default sync pattern and frame length, and byte-stream field widths.
package psk_frame_pkg;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    PAYLOAD = 2'd1,
    CHECK   = 2'd2
  } state_t;

  localparam int          SYNC_W          = 16;
  localparam int          DIST_W          = 5;
  localparam logic [15:0] DEF_SYNC_WORD   = 16'hEB90;
  localparam int          DEF_FRAME_BYTES = 32;

  localparam int TDATA_W = 8;
  localparam int TUSER_W = 1;

endpackage

// File: rtl/sync_correlator.sv
// Combinational sync correlator: Hamming distance of a 16-bit window to the
// sync word and to its complement, with match flags against the error limit.
module sync_correlator
  import psk_frame_pkg::*;
#(
  parameter logic [SYNC_W-1:0] SYNC_WORD = DEF_SYNC_WORD,
  parameter int                ERR_MAX   = 1
) (
  input  logic [SYNC_W-1:0] i_word,
  output logic [DIST_W-1:0] o_dist,
  output logic [DIST_W-1:0] o_distInv,
  output logic              o_match,
  output logic              o_matchInv
);

  logic [SYNC_W-1:0] w_diff;
  logic [DIST_W-1:0] w_dist;

  always_comb begin
    w_diff = i_word ^ SYNC_WORD;
    w_dist = '0;
    for (int i = 0; i < SYNC_W; i++) begin
      w_dist = w_dist + DIST_W'(w_diff[i]);
    end
  end

  // Distance to the complemented word follows directly from d + di = 16.
  assign o_dist     = w_dist;
  assign o_distInv  = DIST_W'(SYNC_W) - w_dist;
  assign o_match    = (w_dist <= DIST_W'(ERR_MAX));
  assign o_matchInv = (o_distInv <= DIST_W'(ERR_MAX));

endmodule

// File: rtl/rx_frame_sync.sv
// Receive frame synchroniser: hunts for the sync word in the demodulated bit
// stream, resolves BPSK phase from its polarity and emits payload bytes.
module rx_frame_sync
  import psk_frame_pkg::*;
#(
  parameter logic [SYNC_W-1:0] SYNC_WORD    = DEF_SYNC_WORD,
  parameter int                FRAME_BYTES  = DEF_FRAME_BYTES,
  parameter int                SYNC_ERR_MAX = 1,
  parameter int                MISS_MAX     = 2
) (
  input  logic               clk_16M384,
  input  logic               rst_16M384,
  input  logic               bit_in,
  input  logic               bit_valid,
  output logic [TDATA_W-1:0] data_tdata,
  output logic               data_tvalid,
  output logic [TUSER_W-1:0] data_tuser,
  output logic               data_tlast,
  output logic               locked,
  output logic               inverted,
  output logic [15:0]        frame_cnt,
  output logic [15:0]        lost_cnt
);

  state_t       r_state, w_stateNext;
  logic [14:0]  r_sr, w_srNext;
  logic [4:0]   r_fill, w_fillNext;
  logic [2:0]   r_bitCnt, w_bitCntNext;
  logic [7:0]   r_byteCnt, w_byteCntNext;
  logic [3:0]   r_missCnt, w_missCntNext;
  logic [6:0]   r_byte, w_byteNext;
  logic         r_locked, w_lockedNext;
  logic         r_inverted, w_invertedNext;
  logic [7:0]   r_tdata, w_tdataNext;
  logic         r_tvalid, w_tvalidNext;
  logic         r_tuser, w_tuserNext;
  logic         r_tlast, w_tlastNext;
  logic [15:0]  r_frameCnt, w_frameCntNext;
  logic [15:0]  r_lostCnt, w_lostCntNext;

  logic [15:0]       w_window;
  logic [7:0]        w_byteFull;
  logic [DIST_W-1:0] w_dist, w_distInv;
  logic              w_match, w_matchInv;
  logic              w_sameMatch, w_oppMatch;
  logic [4:0]        w_missInc;

  // Only 15 history bits are stored; the incoming bit completes the window.
  assign w_window   = {r_sr, bit_in};
  assign w_byteFull = {r_byte, bit_in ^ r_inverted};
  assign w_missInc  = {1'b0, r_missCnt} + 5'd1;

  sync_correlator #(
    .SYNC_WORD (SYNC_WORD),
    .ERR_MAX   (SYNC_ERR_MAX)
  ) u_corr (
    .i_word     (w_window),
    .o_dist     (w_dist),
    .o_distInv  (w_distInv),
    .o_match    (w_match),
    .o_matchInv (w_matchInv)
  );

  // While locked, "same" polarity is relative to the current phase decision.
  assign w_sameMatch = (r_inverted ? w_distInv : w_dist) <= DIST_W'(SYNC_ERR_MAX);
  assign w_oppMatch  = (r_inverted ? w_dist : w_distInv) <= DIST_W'(SYNC_ERR_MAX);

  always_comb begin
    w_stateNext    = r_state;
    w_srNext       = r_sr;
    w_fillNext     = r_fill;
    w_bitCntNext   = r_bitCnt;
    w_byteCntNext  = r_byteCnt;
    w_missCntNext  = r_missCnt;
    w_byteNext     = r_byte;
    w_lockedNext   = r_locked;
    w_invertedNext = r_inverted;
    w_tdataNext    = r_tdata;
    w_tvalidNext   = 1'b0;
    w_tuserNext    = 1'b0;
    w_tlastNext    = 1'b0;
    w_frameCntNext = r_frameCnt;
    w_lostCntNext  = r_lostCnt;
    if (bit_valid) begin
      w_srNext = w_window[14:0];
      case (r_state)
        HUNT: begin
          if (r_fill != 5'd16) w_fillNext = r_fill + 5'd1;
          if (r_fill >= 5'd15 && (w_match || w_matchInv)) begin
            w_lockedNext   = 1'b1;
            w_invertedNext = !w_match;
            w_stateNext    = PAYLOAD;
            w_bitCntNext   = '0;
            w_byteCntNext  = '0;
            w_missCntNext  = '0;
          end
        end
        PAYLOAD: begin
          w_byteNext   = w_byteFull[6:0];
          w_bitCntNext = r_bitCnt + 3'd1;
          if (r_bitCnt == 3'd7) begin
            w_tvalidNext = 1'b1;
            w_tdataNext  = w_byteFull;
            w_tuserNext  = (r_byteCnt == 8'd0);
            w_tlastNext  = (r_byteCnt == 8'(FRAME_BYTES - 1));
            if (r_byteCnt == 8'(FRAME_BYTES - 1)) begin
              w_frameCntNext = r_frameCnt + 16'd1;
              w_byteCntNext  = '0;
              w_fillNext     = '0;
              w_stateNext    = CHECK;
            end else begin
              w_byteCntNext = r_byteCnt + 8'd1;
            end
          end
        end
        CHECK: begin
          w_fillNext = r_fill + 5'd1;
          if (r_fill == 5'd15) begin
            w_bitCntNext  = '0;
            w_byteCntNext = '0;
            w_stateNext   = PAYLOAD;
            if (w_sameMatch) begin
              w_missCntNext = '0;
            end else if (w_oppMatch) begin
              w_invertedNext = !r_inverted;
              w_missCntNext  = '0;
            end else if (w_missInc < 5'(MISS_MAX)) begin
              w_missCntNext = w_missInc[3:0];
            end else begin
              w_lockedNext   = 1'b0;
              w_invertedNext = 1'b0;
              w_lostCntNext  = r_lostCnt + 16'd1;
              w_missCntNext  = '0;
              w_fillNext     = '0;
              w_stateNext    = HUNT;
            end
          end
        end
        default: w_stateNext = HUNT;
      endcase
    end
  end

  always_ff @(posedge clk_16M384 or posedge rst_16M384) begin
    if (rst_16M384) begin
      r_state    <= HUNT;
      r_sr       <= '0;
      r_fill     <= '0;
      r_bitCnt   <= '0;
      r_byteCnt  <= '0;
      r_missCnt  <= '0;
      r_byte     <= '0;
      r_locked   <= 1'b0;
      r_inverted <= 1'b0;
      r_tdata    <= '0;
      r_tvalid   <= 1'b0;
      r_tuser    <= 1'b0;
      r_tlast    <= 1'b0;
      r_frameCnt <= '0;
      r_lostCnt  <= '0;
    end else begin
      r_state    <= w_stateNext;
      r_sr       <= w_srNext;
      r_fill     <= w_fillNext;
      r_bitCnt   <= w_bitCntNext;
      r_byteCnt  <= w_byteCntNext;
      r_missCnt  <= w_missCntNext;
      r_byte     <= w_byteNext;
      r_locked   <= w_lockedNext;
      r_inverted <= w_invertedNext;
      r_tdata    <= w_tdataNext;
      r_tvalid   <= w_tvalidNext;
      r_tuser    <= w_tuserNext;
      r_tlast    <= w_tlastNext;
      r_frameCnt <= w_frameCntNext;
      r_lostCnt  <= w_lostCntNext;
    end
  end

  assign data_tdata  = r_tdata;
  assign data_tvalid = r_tvalid;
  assign data_tuser  = r_tuser;
  assign data_tlast  = r_tlast;
  assign locked      = r_locked;
  assign inverted    = r_inverted;
  assign frame_cnt   = r_frameCnt;
  assign lost_cnt    = r_lostCnt;

endmodule

// File: tb/tb_rx_frame_sync.sv
// Directed testbench for rx_frame_sync with a 4-byte frame, one tolerated
// sync bit error and lock loss after two consecutive missed syncs.
module tb_rx_frame_sync;

  logic        clk = 1'b0;
  logic        rst;
  logic        bitIn;
  logic        bitValid;
  logic [7:0]  tdata;
  logic        tvalid;
  logic        tuser;
  logic        tlast;
  logic        locked;
  logic        inverted;
  logic [15:0] frameCnt;
  logic [15:0] lostCnt;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] qData[$];
  logic       qUser[$];
  logic       qLast[$];

  rx_frame_sync #(
    .SYNC_WORD    (16'hEB90),
    .FRAME_BYTES  (4),
    .SYNC_ERR_MAX (1),
    .MISS_MAX     (2)
  ) dut (
    .clk_16M384  (clk),
    .rst_16M384  (rst),
    .bit_in      (bitIn),
    .bit_valid   (bitValid),
    .data_tdata  (tdata),
    .data_tvalid (tvalid),
    .data_tuser  (tuser),
    .data_tlast  (tlast),
    .locked      (locked),
    .inverted    (inverted),
    .frame_cnt   (frameCnt),
    .lost_cnt    (lostCnt)
  );

  always #5 clk = ~clk;

  // Every delivered byte is logged on the falling edge, clear of the active edge.
  always @(negedge clk) begin
    if (tvalid === 1'b1) begin
      qData.push_back(tdata);
      qUser.push_back(tuser);
      qLast.push_back(tlast);
    end
  end

  task automatic clearLog;
    qData.delete();
    qUser.delete();
    qLast.delete();
  endtask

  task automatic sendBit(input logic b, input int gap);
    bitIn    = b;
    bitValid = 1'b1;
    @(negedge clk);
    bitValid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic sendByte(input logic [7:0] v, input int gap);
    for (int i = 7; i >= 0; i--) sendBit(v[i], gap);
  endtask

  task automatic sendWord(input logic [15:0] v, input int gap);
    for (int i = 15; i >= 0; i--) sendBit(v[i], gap);
  endtask

  task automatic applyReset;
    bitValid = 1'b0;
    bitIn    = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clearLog();
  endtask

  task automatic test_reset;
    applyReset();
    vectors++;
    if ({tvalid, tuser, tlast, tdata} !== 11'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_stream got %b want 0", {tvalid, tuser, tlast, tdata});
    end
    vectors++;
    if ({locked, inverted} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL reset_lock got %b want 00", {locked, inverted});
    end
    vectors++;
    if ({frameCnt, lostCnt} !== 32'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_counters got %h want 0", {frameCnt, lostCnt});
    end
  endtask

  task automatic test_clean_normal;
    logic [9:0] got;
    applyReset();
    sendWord(16'hEB90, 0);
    for (int i = 1; i <= 4; i++) sendByte(8'(i), 0);
    repeat (2) @(negedge clk);
    vectors++;
    if (qData.size() !== 4) begin
      miscompares++;
      $display("[TB] FAIL normal_count got %0d want 4", qData.size());
    end
    for (int i = 0; i < 4; i++) begin
      got = (i < qData.size()) ? {qData[i], qUser[i], qLast[i]} : 10'bx;
      vectors++;
      if (got !== {8'(i + 1), i == 0, i == 3}) begin
        miscompares++;
        $display("[TB] FAIL normal_byte%0d got %h want %h", i, got, {8'(i + 1), i == 0, i == 3});
      end
    end
    vectors++;
    if ({locked, inverted, frameCnt} !== {2'b10, 16'd1}) begin
      miscompares++;
      $display("[TB] FAIL normal_status got %h want %h", {locked, inverted, frameCnt}, {2'b10, 16'd1});
    end
  endtask

  task automatic test_clean_inverted;
    logic [9:0] got;
    applyReset();
    sendWord(16'h146F, 0);
    for (int i = 1; i <= 4; i++) sendByte(~8'(i), 0);
    repeat (2) @(negedge clk);
    vectors++;
    if (qData.size() !== 4) begin
      miscompares++;
      $display("[TB] FAIL inv_count got %0d want 4", qData.size());
    end
    for (int i = 0; i < 4; i++) begin
      got = (i < qData.size()) ? {qData[i], qUser[i], qLast[i]} : 10'bx;
      vectors++;
      if (got !== {8'(i + 1), i == 0, i == 3}) begin
        miscompares++;
        $display("[TB] FAIL inv_byte%0d got %h want %h", i, got, {8'(i + 1), i == 0, i == 3});
      end
    end
    vectors++;
    if ({locked, inverted, frameCnt} !== {2'b11, 16'd1}) begin
      miscompares++;
      $display("[TB] FAIL inv_status got %h want %h", {locked, inverted, frameCnt}, {2'b11, 16'd1});
    end
  endtask

  task automatic test_error_tolerance;
    logic [15:0] partial;
    applyReset();
    sendWord(16'hEB91, 0);
    for (int i = 1; i <= 4; i++) sendByte(8'(i), 0);
    repeat (2) @(negedge clk);
    vectors++;
    if ({locked, 8'(qData.size())} !== {1'b1, 8'd4}) begin
      miscompares++;
      $display("[TB] FAIL err1_lock got %h want %h", {locked, 8'(qData.size())}, {1'b1, 8'd4});
    end

    applyReset();
    sendWord(16'hEB93, 0);
    for (int i = 1; i <= 4; i++) sendByte(8'(i), 0);
    repeat (2) @(negedge clk);
    vectors++;
    if ({locked, 8'(qData.size())} !== {1'b0, 8'd0}) begin
      miscompares++;
      $display("[TB] FAIL err2_nolock got %h want %h", {locked, 8'(qData.size())}, {1'b0, 8'd0});
    end

    // The 15 low bits of the sync word already sit within one bit of it.
    applyReset();
    partial = 16'hEB90;
    for (int i = 14; i >= 0; i--) sendBit(partial[i], 0);
    repeat (2) @(negedge clk);
    vectors++;
    if (locked !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL fill15_nolock got %b want 0", locked);
    end
  endtask

  task automatic test_flywheel;
    logic [9:0] got;
    applyReset();
    sendWord(16'hEB90, 0);
    for (int i = 1; i <= 4; i++) sendByte(8'(i), 0);
    sendWord(16'h0000, 0);
    for (int i = 5; i <= 8; i++) sendByte(8'(i), 0);
    repeat (2) @(negedge clk);
    vectors++;
    if (qData.size() !== 8) begin
      miscompares++;
      $display("[TB] FAIL fly_count got %0d want 8", qData.size());
    end
    for (int i = 4; i < 8; i++) begin
      got = (i < qData.size()) ? {qData[i], qUser[i], qLast[i]} : 10'bx;
      vectors++;
      if (got !== {8'(i + 1), i == 4, i == 7}) begin
        miscompares++;
        $display("[TB] FAIL fly_byte%0d got %h want %h", i, got, {8'(i + 1), i == 4, i == 7});
      end
    end
    vectors++;
    if ({locked, frameCnt, lostCnt} !== {1'b1, 16'd2, 16'd0}) begin
      miscompares++;
      $display("[TB] FAIL fly_status got %h want %h", {locked, frameCnt, lostCnt}, {1'b1, 16'd2, 16'd0});
    end

    clearLog();
    sendWord(16'h0000, 0);
    @(negedge clk);
    vectors++;
    if ({locked, inverted, lostCnt} !== {2'b00, 16'd1}) begin
      miscompares++;
      $display("[TB] FAIL lost_status got %h want %h", {locked, inverted, lostCnt}, {2'b00, 16'd1});
    end
    for (int i = 9; i <= 12; i++) sendByte(8'(i), 0);
    repeat (2) @(negedge clk);
    vectors++;
    if ({8'(qData.size()), frameCnt} !== {8'd0, 16'd2}) begin
      miscompares++;
      $display("[TB] FAIL lost_nobytes got %h want %h", {8'(qData.size()), frameCnt}, {8'd0, 16'd2});
    end
  endtask

  task automatic test_phase_slip;
    logic [9:0] got;
    applyReset();
    sendWord(16'hEB90, 0);
    for (int i = 1; i <= 4; i++) sendByte(8'(i), 0);
    sendWord(16'h146F, 0);
    vectors++;
    if ({locked, inverted} !== 2'b11) begin
      miscompares++;
      $display("[TB] FAIL slip_flip got %b want 11", {locked, inverted});
    end
    for (int i = 1; i <= 4; i++) sendByte(~8'(i), 0);
    // A miss here must not drop lock, proving the slip reset the miss count.
    sendWord(16'h0000, 0);
    for (int i = 5; i <= 8; i++) sendByte(~8'(i), 0);
    repeat (2) @(negedge clk);
    vectors++;
    if (qData.size() !== 12) begin
      miscompares++;
      $display("[TB] FAIL slip_count got %0d want 12", qData.size());
    end
    for (int i = 4; i < 12; i++) begin
      got = (i < qData.size()) ? {qData[i], qUser[i], qLast[i]} : 10'bx;
      vectors++;
      if (got !== {8'(i - 3), (i % 4) == 0, (i % 4) == 3}) begin
        miscompares++;
        $display("[TB] FAIL slip_byte%0d got %h want %h", i, got, {8'(i - 3), (i % 4) == 0, (i % 4) == 3});
      end
    end
    vectors++;
    if ({locked, inverted, frameCnt, lostCnt} !== {2'b11, 16'd3, 16'd0}) begin
      miscompares++;
      $display("[TB] FAIL slip_status got %h want %h", {locked, inverted, frameCnt, lostCnt}, {2'b11, 16'd3, 16'd0});
    end
  endtask

  task automatic test_sparse_timing;
    logic [9:0] got;
    logic [7:0] first;
    applyReset();
    sendWord(16'hEB90, 15);
    first = 8'h01;
    for (int i = 7; i >= 1; i--) sendBit(first[i], 15);
    vectors++;
    if (tvalid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL lat_early got %b want 0", tvalid);
    end
    sendBit(first[0], 0);
    vectors++;
    if ({tvalid, tuser, tdata} !== {2'b11, 8'h01}) begin
      miscompares++;
      $display("[TB] FAIL lat_onecycle got %h want %h", {tvalid, tuser, tdata}, {2'b11, 8'h01});
    end
    @(negedge clk);
    vectors++;
    if (tvalid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL lat_pulse got %b want 0", tvalid);
    end
    repeat (14) @(negedge clk);
    for (int i = 2; i <= 4; i++) sendByte(8'(i), 15);
    repeat (2) @(negedge clk);
    vectors++;
    if (qData.size() !== 4) begin
      miscompares++;
      $display("[TB] FAIL sparse_count got %0d want 4", qData.size());
    end
    for (int i = 0; i < 4; i++) begin
      got = (i < qData.size()) ? {qData[i], qUser[i], qLast[i]} : 10'bx;
      vectors++;
      if (got !== {8'(i + 1), i == 0, i == 3}) begin
        miscompares++;
        $display("[TB] FAIL sparse_byte%0d got %h want %h", i, got, {8'(i + 1), i == 0, i == 3});
      end
    end
  endtask

  task automatic test_reset_midframe;
    logic [9:0] got;
    applyReset();
    sendWord(16'hEB90, 0);
    sendByte(8'h01, 0);
    sendByte(8'h02, 0);
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({tvalid, tuser, tlast, tdata, locked, inverted, frameCnt} !== 29'd0) begin
      miscompares++;
      $display("[TB] FAIL midreset_async got %h want 0", {tvalid, tuser, tlast, tdata, locked, inverted, frameCnt});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clearLog();
    sendByte(8'h03, 0);
    sendByte(8'h04, 0);
    sendWord(16'h0000, 0);
    sendWord(16'hEB90, 0);
    for (int i = 1; i <= 4; i++) sendByte(8'(i), 0);
    repeat (2) @(negedge clk);
    vectors++;
    if (qData.size() !== 4) begin
      miscompares++;
      $display("[TB] FAIL resync_count got %0d want 4", qData.size());
    end
    for (int i = 0; i < 4; i++) begin
      got = (i < qData.size()) ? {qData[i], qUser[i], qLast[i]} : 10'bx;
      vectors++;
      if (got !== {8'(i + 1), i == 0, i == 3}) begin
        miscompares++;
        $display("[TB] FAIL resync_byte%0d got %h want %h", i, got, {8'(i + 1), i == 0, i == 3});
      end
    end
    vectors++;
    if ({locked, frameCnt} !== {1'b1, 16'd1}) begin
      miscompares++;
      $display("[TB] FAIL resync_status got %h want %h", {locked, frameCnt}, {1'b1, 16'd1});
    end
  endtask

  initial begin
    rst      = 1'b1;
    bitValid = 1'b0;
    bitIn    = 1'b0;
    test_reset();
    test_clean_normal();
    test_clean_inverted();
    test_error_tolerance();
    test_flywheel();
    test_phase_slip();
    test_sparse_timing();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rx_frame_sync.md
Name: rx_frame_sync

Overview:
- Receive-side counterpart of the Tx framer/serializer.
- Consumes the demodulated serial bit stream (Rx_1bit / Rx_valid style strobe, retimed into the 16.384 MHz domain) and hunts for the frame sync word.
- Resolves the 180° BPSK phase ambiguity from the sync polarity.
- Re-assembles payload bytes and emits them as a byte stream with data_tdata/tvalid/tuser/tlast, matching the Tx data interface so loopback frames compare byte-for-byte.

Parameters:
- SYNC_WORD, 16'hEB90, 16-bit frame sync pattern, MSB first.
- FRAME_BYTES, 32, payload bytes per frame (2..255).
- SYNC_ERR_MAX, 1, max Hamming distance accepted as a sync match (0..7).
- MISS_MAX, 2, consecutive missed syncs while locked before returning to hunt (1..15).

Ports:
- clk_16M384  in  1  system clock
- rst_16M384  in  1  asynchronous reset, active-high
- bit_in  in  1  demodulated hard bit
- bit_valid  in  1  single-cycle strobe, bit_in valid; may be high on consecutive cycles
- data_tdata  out  8  payload byte, MSB = first received bit
- data_tvalid  out  1  one-cycle byte strobe; no backpressure
- data_tuser  out  1  first byte of frame, qualified by tvalid
- data_tlast  out  1  last byte of frame, qualified by tvalid
- locked  out  1  frame sync acquired
- inverted  out  1  stream received with 180° phase; payload bits are complemented
- frame_cnt  out  16  frames delivered, wraps 65535→0
- lost_cnt  out  16  lock-loss events, wraps

Behaviour:
- Reset (async):
  - All outputs 0, state HUNT.
  - Shift register, fill counter, bit/byte/miss counters cleared.
  - A partial frame is discarded; no tlast is ever issued for it.
- Shift register: on each bit_valid, sr <= {sr[14:0], bit_in}.
- Sync distance: d = popcount(next_sr ^ SYNC_WORD); inverse distance di = 16 - d.
- HUNT:
  - fill counter saturates at 16; no match is evaluated until 16 bits have been received since entering HUNT.
  - d <= SYNC_ERR_MAX → inverted=0, locked=1, go PAYLOAD.
  - Otherwise di <= SYNC_ERR_MAX → inverted=1, locked=1, go PAYLOAD.
  - Non-inverted match has priority.
- PAYLOAD:
  - Each strobe shifts (bit_in ^ inverted) into the byte register and increments bit_cnt (0..7).
  - On the 8th bit, the registered outputs assert the next cycle: tvalid=1, tdata=byte, tuser=(byte_cnt==0), tlast=(byte_cnt==FRAME_BYTES-1). Latency is one clock after the 8th bit_valid.
  - On tlast: frame_cnt++, go CHECK.
  - tvalid/tuser/tlast are 0 on every other cycle.
- CHECK: collect 16 bits, then evaluate (cleared fill counter, same correlator):
  - Same-polarity match → miss_cnt=0, go PAYLOAD.
  - Opposite-polarity match (phase slip) → toggle inverted, miss_cnt=0, go PAYLOAD.
  - No match, miss_cnt+1 < MISS_MAX → miss_cnt++, go PAYLOAD (flywheel); that frame's payload is delivered.
  - No match, miss_cnt+1 == MISS_MAX → locked=0, inverted=0, lost_cnt++, go HUNT with fill counter cleared. The following payload is not delivered.
- Counters wrap silently.
- bit_valid with no state change (e.g. HUNT mismatch) only updates sr and fill.

Decomposition:
- Package psk_frame_pkg holds:
  - state encoding (HUNT, PAYLOAD, CHECK)
  - default SYNC_WORD 16'hEB90
  - default FRAME_BYTES
  - byte-stream field widths, shared with the Tx framer
- One combinational sub-module, sync_correlator: 16-bit XOR plus popcount, producing d and di (5 bits each) plus match/match_inv flags against SYNC_ERR_MAX.

Test Plan (FRAME_BYTES=4, SYNC_ERR_MAX=1, MISS_MAX=2):
1. Clean frame, normal polarity: after reset send 0xEB90, then 0x01,0x02,0x03,0x04 → four tvalid pulses with tdata 01..04; tuser only on 01, tlast only on 04; locked=1, inverted=0, frame_cnt=1.
2. Clean frame, inverted: send 0x146F, then 0xFE,0xFD,0xFC,0xFB → output 01..04, inverted=1, frame_cnt=1.
3. Error tolerance:
   - Sync 0xEB91 (1 error) → lock and bytes delivered.
   - Sync 0xEB93 (2 errors) → locked stays 0, no tvalid.
   - 15 leading bits after reset that happen to match → no lock.
4. Flywheel and lock loss: locked, then frame with sync 0x0000 → payload still delivered, locked=1. Second consecutive 0x0000 → locked=0, lost_cnt=1, no bytes from that frame.
5. Phase slip: locked normal, next sync arrives as 0x146F with complemented payload → inverted toggles to 1, payload decoded correctly, no miss counted.
6. Timing and reset:
   - bit_valid every cycle vs every 16 cycles → identical bytes; tvalid exactly one clock after each 8th strobe.
   - Reset asserted after byte 2 → all outputs 0 immediately; no tlast; clean resync on the next frame.
